conv33_input: RTL

- Source-side stream feeder for the 3x3 convolution datapath; counterpart of the conv output sink stage.
- On a start pulse, reads `length` consecutive words from a registered on-chip feature-map RAM starting at `base_addr`.
- Presents the words on a valid/ready stream with full backpressure support, flags the final beat, and pulses `done` after the last beat is accepted.
- Sustains 1 beat/cycle when `ready_in` is held high.

---
 rtl/conv33_input.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/conv33_input.sv
// conv33_input: reads a block of words from a registered feature-map RAM and
// streams them out on a valid/ready interface with last/done signalling.
`default_nettype none

module conv33_input #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic [LEN_WIDTH-1:0]  r_accepted;
  logic                  r_pending;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_is_last;
  logic [2:0]            w_occ;
  logic                  w_rd_en;

  assign valid_out   = (r_count != 2'd0);
  assign data_out    = r_mem[r_rptr];
  assign w_pop       = valid_out && ready_in;
  assign w_is_last   = (r_accepted == (r_len - LEN_ONE));
  assign last_out    = valid_out && w_is_last;
  assign mem_rd_en   = w_rd_en;
  assign mem_rd_addr = r_base + r_issued[ADDR_WIDTH-1:0];

  // Words still owed to the FIFO after this cycle's pop; a new read is only
  // issued when its data is guaranteed a free slot on arrival.
  assign w_occ = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    w_rd_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = (length == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        w_rd_en = (r_issued < r_len) && (w_occ < 3'd2);
        if (w_pop && w_is_last) begin
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_pending <= w_rd_en;
      if (w_accept) begin
        r_base     <= base_addr;
        r_len      <= length;
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (w_rd_en) begin
          r_issued <= r_issued + LEN_ONE;
        end
        if (w_pop) begin
          r_accepted <= r_accepted + LEN_ONE;
        end
      end
    end
  end

  // Two-entry FIFO fed by the RAM data that returns one cycle after each read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_pending) begin
        r_mem[r_wptr] <= mem_rd_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, r_pending} - {1'b0, w_pop};
    end
  end

endmodule

`default_nettype wire
